// File: rtl/elevator_request_panel_if.sv
// Bundle of button, back-pressure and command signals between the request panel
// and its surroundings; the panel itself uses the slave view.
interface elevator_request_panel_if #(
   parameter int NFLOORS = 8
);
   logic [NFLOORS-1:0] btn_floor;
   logic               btn_cancel;
   logic               btn_list;
   logic               list_busy;
   logic [1:0]         mode;
   logic [3:0]         request;
   logic [4:0]         pend_count;

   modport master (
      output btn_floor, btn_cancel, btn_list, list_busy,
      input  mode, request, pend_count
   );

   modport slave (
      input  btn_floor, btn_cancel, btn_list, list_busy,
      output mode, request, pend_count
   );
endinterface

// File: rtl/elevator_request_panel.sv
// Debounces floor/cancel/list buttons, latches pending add/delete/list commands and
// issues them one per slot to the elevator controller, driving run (11) otherwise.
module elevator_request_panel #(
   parameter int NFLOORS    = 8,
   parameter int DEB_CYCLES = 4
) (
   input logic                     CLK,
   input logic                     RESET_N,
   elevator_request_panel_if.slave bus
);
   localparam int NB       = NFLOORS + 2;
   localparam int CANCEL_B = NFLOORS;
   localparam int LIST_B   = NFLOORS + 1;
   localparam int CW       = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      GAP   = 2'b10
   } state_t;

   logic [NB-1:0]      raw_s;
   logic [NB-1:0]      sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
   logic [CW-1:0]      cnt_q [NB];
   logic [CW-1:0]      cnt_d [NB];
   logic [NFLOORS-1:0] pend_add_q, pend_add_d, pend_del_q, pend_del_d;
   logic               pend_list_q, pend_list_d;
   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [3:0]         request_q, request_d;
   logic [4:0]         pend_count_q, pend_count_d;

   logic [NFLOORS-1:0] press_floor_s, add_set_s, del_set_s;
   logic [NFLOORS-1:0] clr_add_s, clr_del_s, add_low_s, del_low_s;
   logic [NFLOORS-1:0] win_add_s, win_del_s;
   logic               press_list_s, cancel_s, clr_list_s, win_list_s, any_pend_s;
   logic [1:0]         win_mode_s;
   logic [3:0]         win_req_s;

   function automatic logic [4:0] popcount(input logic [NFLOORS-1:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < NFLOORS; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

   assign raw_s = {bus.btn_list, bus.btn_cancel, bus.btn_floor};

   // Level only flips after DEB_CYCLES consecutive synchronised samples disagree with it.
   always_comb begin
      sync1_d = raw_s;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      for (int b = 0; b < NB; b++) begin
         cnt_d[b] = '0;
         if (sync2_q[b] != deb_q[b]) begin
            if (cnt_q[b] == CW'(DEB_CYCLES - 1)) begin
               deb_d[b] = ~deb_q[b];
               cnt_d[b] = '0;
            end else begin
               cnt_d[b] = cnt_q[b] + CW'(1);
            end
         end else begin
            cnt_d[b] = '0;
         end
      end
   end

   assign press_floor_s = deb_d[NFLOORS-1:0] & ~deb_q[NFLOORS-1:0];
   assign press_list_s  = deb_d[LIST_B] & ~deb_q[LIST_B];
   assign cancel_s      = deb_q[CANCEL_B];
   assign any_pend_s    = pend_list_q | (|pend_add_q) | (|pend_del_q);
   assign add_low_s     = pend_add_q & (~pend_add_q + NFLOORS'(1));
   assign del_low_s     = pend_del_q & (~pend_del_q + NFLOORS'(1));

   // Winner: list first, then lowest pending delete, then lowest pending add.
   always_comb begin
      win_mode_s = 2'b11;
      win_req_s  = 4'd0;
      win_add_s  = '0;
      win_del_s  = '0;
      win_list_s = 1'b0;
      if (pend_list_q) begin
         win_mode_s = 2'b01;
         win_list_s = 1'b1;
      end else if (|pend_del_q) begin
         win_mode_s = 2'b10;
         win_del_s  = del_low_s;
      end else if (|pend_add_q) begin
         win_mode_s = 2'b00;
         win_add_s  = add_low_s;
      end else begin
         win_mode_s = 2'b11;
      end
      for (int k = 0; k < NFLOORS; k++) begin
         win_req_s = win_req_s | ((win_add_s[k] | win_del_s[k]) ? 4'(k + 1) : 4'd0);
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = 2'b11;
      request_d  = 4'd0;
      clr_add_s  = '0;
      clr_del_s  = '0;
      clr_list_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.list_busy && any_pend_s) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            mode_d     = win_mode_s;
            request_d  = win_req_s;
            clr_add_s  = win_add_s;
            clr_del_s  = win_del_s;
            clr_list_s = win_list_s;
            state_d    = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // New presses win over the issue-clear, so a same-cycle re-press survives.
      add_set_s    = press_floor_s & {NFLOORS{~cancel_s}};
      del_set_s    = press_floor_s & {NFLOORS{cancel_s}};
      pend_add_d   = (pend_add_q & ~clr_add_s & ~del_set_s) | add_set_s;
      pend_del_d   = (pend_del_q & ~clr_del_s & ~add_set_s) | del_set_s;
      pend_list_d  = (pend_list_q & ~clr_list_s) | press_list_s;
      pend_count_d = popcount(pend_add_q) + popcount(pend_del_q) + {4'd0, pend_list_q};
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         for (int b = 0; b < NB; b++) begin
            cnt_q[b] <= '0;
         end
         pend_add_q   <= '0;
         pend_del_q   <= '0;
         pend_list_q  <= 1'b0;
         state_q      <= IDLE;
         mode_q       <= 2'b11;
         request_q    <= 4'd0;
         pend_count_q <= 5'd0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         deb_q        <= deb_d;
         for (int b = 0; b < NB; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
         pend_add_q   <= pend_add_d;
         pend_del_q   <= pend_del_d;
         pend_list_q  <= pend_list_d;
         state_q      <= state_d;
         mode_q       <= mode_d;
         request_q    <= request_d;
         pend_count_q <= pend_count_d;
      end
   end

   assign bus.mode       = mode_q;
   assign bus.request    = request_q;
   assign bus.pend_count = pend_count_q;
endmodule

// File: tb/tb_elevator_request_panel.sv
// Directed bench for elevator_request_panel: a per-cycle vector table for the basic
// press/glitch/ordering cases, then hand sequences for back-pressure and reset.
module tb_elevator_request_panel;
   logic CLK;
   logic RESET_N;
   int   checks;
   int   errors;
   logic [5:0] cmd_log [$];

   elevator_request_panel_if #(.NFLOORS(8)) bus ();

   elevator_request_panel #(.NFLOORS(8), .DEB_CYCLES(4)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   typedef struct {
      int         n;
      logic [7:0] fl;
      logic [1:0] mode;
      logic [3:0] req;
      logic [4:0] cnt;
   } vec_t;

   vec_t tbl [$];

   always #5 CLK = ~CLK;

   // Record every non-run command seen on the output.
   always @(negedge CLK) begin
      if (RESET_N && bus.mode != 2'b11) cmd_log.push_back({bus.mode, bus.request});
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      RESET_N        = 1'b0;
      bus.btn_floor  = 8'h00;
      bus.btn_cancel = 1'b0;
      bus.btn_list   = 1'b0;
      bus.list_busy  = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RESET_N = 1'b1;
   endtask

   initial begin
      CLK    = 1'b0;
      checks = 0;
      errors = 0;
      do_reset();
      check("reset_mode", int'(bus.mode), 3);
      check("reset_request", int'(bus.request), 0);
      check("reset_count", int'(bus.pend_count), 0);

      // floor 3 held 10 cycles: pending at 6, count at 7, add 3 shown at 8
      tbl.push_back('{6,  8'h04, 2'b11, 4'd0, 5'd0});
      tbl.push_back('{1,  8'h04, 2'b11, 4'd0, 5'd1});
      tbl.push_back('{1,  8'h04, 2'b00, 4'd3, 5'd1});
      tbl.push_back('{2,  8'h04, 2'b11, 4'd0, 5'd0});
      tbl.push_back('{10, 8'h00, 2'b11, 4'd0, 5'd0});
      // 3-cycle glitch on floor 1: nothing happens
      tbl.push_back('{3,  8'h01, 2'b11, 4'd0, 5'd0});
      tbl.push_back('{12, 8'h00, 2'b11, 4'd0, 5'd0});
      // floors 5 and 2 together: add 2, run, run, add 5
      tbl.push_back('{6,  8'h12, 2'b11, 4'd0, 5'd0});
      tbl.push_back('{1,  8'h12, 2'b11, 4'd0, 5'd2});
      tbl.push_back('{1,  8'h12, 2'b00, 4'd2, 5'd2});
      tbl.push_back('{2,  8'h12, 2'b11, 4'd0, 5'd1});
      tbl.push_back('{1,  8'h00, 2'b00, 4'd5, 5'd1});
      tbl.push_back('{11, 8'h00, 2'b11, 4'd0, 5'd0});

      for (int i = 0; i < tbl.size(); i++) begin
         for (int j = 0; j < tbl[i].n; j++) begin
            bus.btn_floor = tbl[i].fl;
            tick();
            check($sformatf("vec%0d_%0d_mode", i, j), int'(bus.mode), int'(tbl[i].mode));
            check($sformatf("vec%0d_%0d_req", i, j), int'(bus.request), int'(tbl[i].req));
            check($sformatf("vec%0d_%0d_cnt", i, j), int'(bus.pend_count), int'(tbl[i].cnt));
         end
      end
      check("table_cmd_total", cmd_log.size(), 3);

      // Add floor 4, then cancel+floor 4 while the controller is busy: only delete 4 issues
      do_reset();
      cmd_log.delete();
      bus.list_busy = 1'b1;
      bus.btn_floor = 8'h08;
      repeat (6) tick();
      bus.btn_floor  = 8'h00;
      bus.btn_cancel = 1'b1;
      repeat (7) tick();
      check("t4_count_add", int'(bus.pend_count), 1);
      bus.btn_floor = 8'h08;
      repeat (7) tick();
      check("t4_count_replaced", int'(bus.pend_count), 1);
      check("t4_no_issue_busy", cmd_log.size(), 0);
      bus.list_busy  = 1'b0;
      bus.btn_floor  = 8'h00;
      bus.btn_cancel = 1'b0;
      repeat (10) tick();
      check("t4_cmd_total", cmd_log.size(), 1);
      if (cmd_log.size() > 0) check("t4_cmd_delete4", int'(cmd_log[0]), 6'b10_0100);
      else check("t4_cmd_present", 0, 1);
      check("t4_count_end", int'(bus.pend_count), 0);

      // List beats a pending add; list_busy holds the add off
      do_reset();
      cmd_log.delete();
      bus.list_busy = 1'b1;
      bus.btn_floor = 8'h20;
      repeat (6) tick();
      bus.btn_floor = 8'h00;
      bus.btn_list  = 1'b1;
      repeat (6) tick();
      bus.btn_list = 1'b0;
      tick();
      check("t5_count_two", int'(bus.pend_count), 2);
      bus.list_busy = 1'b0;
      tick();
      check("t5_pre_mode", int'(bus.mode), 3);
      tick();
      check("t5_list_mode", int'(bus.mode), 1);
      check("t5_list_req", int'(bus.request), 0);
      bus.list_busy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("t5_busy_run%0d", c), int'(bus.mode), 3);
      end
      bus.list_busy = 1'b0;
      tick();
      check("t5_after_busy_run", int'(bus.mode), 3);
      tick();
      check("t5_add_mode", int'(bus.mode), 0);
      check("t5_add_req", int'(bus.request), 6);
      tick();
      check("t5_cmd_total", cmd_log.size(), 2);

      // Reset in the middle of an issued command, then a normal press
      do_reset();
      cmd_log.delete();
      bus.btn_floor = 8'h04;
      repeat (8) tick();
      check("t6_issue_mode", int'(bus.mode), 0);
      check("t6_issue_count", int'(bus.pend_count), 1);
      #2;
      RESET_N = 1'b0;
      #1;
      check("t6_rst_mode", int'(bus.mode), 3);
      check("t6_rst_req", int'(bus.request), 0);
      check("t6_rst_count", int'(bus.pend_count), 0);
      bus.btn_floor = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      cmd_log.delete();
      bus.btn_floor = 8'h02;
      repeat (7) tick();
      check("t6_post_wait_mode", int'(bus.mode), 3);
      tick();
      check("t6_post_mode", int'(bus.mode), 0);
      check("t6_post_req", int'(bus.request), 2);
      bus.btn_floor = 8'h00;
      repeat (4) tick();
      check("t6_cmd_total", cmd_log.size(), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
